// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: synchronises PLL lock and button, debounces the button and releases
// CHANNELS resets in ascending order. Define RESET_SEQUENCER_WATCHDOG_EN to add the RUN watchdog.
module reset_sequencer #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned STRETCH_CYCLES  = 16,
  parameter int unsigned STAGE_GAP       = 8,
  parameter int unsigned BTN_ACTIVE_LOW  = 1
`ifdef RESET_SEQUENCER_WATCHDOG_EN
  ,
  parameter int unsigned WDT_CYCLES      = 1 << 20
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pll_locked,
  input  logic                btn,
`ifdef RESET_SEQUENCER_WATCHDOG_EN
  input  logic                wdt_kick,
`endif
  output logic [CHANNELS-1:0] rst_out,
  output logic                ready,
  output logic [7:0]          abort_count
);

  localparam int unsigned SEQ_MAX = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
  localparam int unsigned CW = $clog2(SEQ_MAX) + 1;
  localparam int unsigned IW = $clog2(CHANNELS) + 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);
  localparam logic [DW-1:0] DB_LAST      = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {HOLD, STRETCH, RELEASE, RUN} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic [IW-1:0]         idx, idx_next;
  logic [CHANNELS-1:0]   rst_next;
  logic                  ready_next;
  logic [7:0]            abort_next;

  logic [SYNC_STAGES-1:0] lock_sync, btn_sync;
  logic                   lock_s, btn_s, press_raw, press_d;
  logic [DW-1:0]          db_cnt;
  logic                   fault, abort_req;

  assign lock_s    = lock_sync[SYNC_STAGES-1];
  assign btn_s     = btn_sync[SYNC_STAGES-1];
  assign press_raw = (BTN_ACTIVE_LOW != 0) ? ~btn_s : btn_s;
  assign fault     = ~lock_s | press_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_sync <= '0;
      btn_sync  <= '0;
      press_d   <= 1'b0;
      db_cnt    <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn};
      if (press_raw != press_d) begin
        if (db_cnt == DB_LAST) begin
          press_d <= press_raw;
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

`ifdef RESET_SEQUENCER_WATCHDOG_EN
  localparam int unsigned WW = $clog2(WDT_CYCLES) + 1;
  localparam logic [WW-1:0] WDT_LIMIT = WW'(WDT_CYCLES);
  logic [WW-1:0] wdt_cnt;
  logic          wdt_fault;

  assign wdt_fault = (state == RUN) && (wdt_cnt == WDT_LIMIT);
  assign abort_req = fault | wdt_fault;

  always_ff @(posedge clk) begin
    if (reset || state != RUN || wdt_kick)
      wdt_cnt <= '0;
    else if (wdt_cnt != WDT_LIMIT)
      wdt_cnt <= wdt_cnt + WW'(1);
  end
`else
  assign abort_req = fault;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HOLD;
      cnt         <= '0;
      idx         <= '0;
      rst_out     <= '1;
      ready       <= 1'b0;
      abort_count <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      idx         <= idx_next;
      rst_out     <= rst_next;
      ready       <= ready_next;
      abort_count <= abort_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    rst_next   = rst_out;
    ready_next = ready;
    abort_next = abort_count;
    // Any fault outside HOLD wins over sequencing and counts once, however many sources fire.
    if (state != HOLD && abort_req) begin
      state_next = HOLD;
      cnt_next   = '0;
      idx_next   = '0;
      rst_next   = '1;
      ready_next = 1'b0;
      if (abort_count != 8'hFF)
        abort_next = abort_count + 8'd1;
    end else begin
      case (state)
        HOLD: begin
          rst_next   = '1;
          ready_next = 1'b0;
          cnt_next   = '0;
          idx_next   = '0;
          if (!fault)
            state_next = STRETCH;
        end
        STRETCH: begin
          if (cnt == STRETCH_LAST) begin
            state_next  = RELEASE;
            cnt_next    = '0;
            rst_next[0] = 1'b0;
            idx_next    = IW'(1);
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (idx == IW'(CHANNELS)) begin
            state_next = RUN;
            ready_next = 1'b1;
          end else if (cnt == GAP_LAST) begin
            cnt_next = '0;
            idx_next = idx + IW'(1);
            for (int unsigned i = 0; i < CHANNELS; i++)
              if (IW'(i) == idx)
                rst_next[i] = 1'b0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        RUN: begin
          rst_next   = '0;
          ready_next = 1'b1;
        end
        default: state_next = HOLD;
      endcase
    end
  end

endmodule
